i2s_adc_receiver: RTL



---
 rtl/i2s_adc_receiver.sv | 115 +++++++++++
 1 files changed

// File: rtl/i2s_adc_receiver.sv
// I2S master receiver for the line-in ADC: generates MCLK/SCK/LRCK and deserializes left/right pairs.
// Optional MONO_MIX_EN adds sample_mono, the floor-mean of left and right.
module i2s_adc_receiver #(
    parameter int DATA_W        = 16,
    parameter int WARMUP_FRAMES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              audio_sdout,
    output logic              audio_mclk,
    output logic              audio_lrck,
    output logic              audio_sck,
    output logic [DATA_W-1:0] sample_left,
    output logic [DATA_W-1:0] sample_right,
    output logic              sample_valid,
    input  logic              sample_ready,
`ifdef MONO_MIX_EN
    output logic [DATA_W-1:0] sample_mono,
`endif
    output logic              overrun
);

    typedef enum logic {WARMUP, RUN} state_t;

    state_t            state;
    logic [8:0]        cnt;
    logic [8:0]        cnt_nxt;
    logic [4:0]        slot;
    logic              bit_strobe;
    logic              last_bit;
    logic              pair_complete;
    logic [3:0]        frame_cnt;
    logic [DATA_W-1:0] left_sr;
    logic [DATA_W-1:0] left_hold;
    logic [DATA_W-1:0] right_sr;
    logic [DATA_W-1:0] left_nxt;
    logic [DATA_W-1:0] right_nxt;

    assign cnt_nxt       = cnt + 9'd1;
    assign slot          = cnt[7:3];
    // slot 0 is the I2S one-bit delay; data occupies slots 1..DATA_W
    assign bit_strobe    = (cnt[2:0] == 3'd5) && (slot != 5'd0) && (slot <= 5'(DATA_W));
    assign last_bit      = bit_strobe && (slot == 5'(DATA_W));
    assign pair_complete = cnt[8] && (slot == 5'(DATA_W)) && (cnt[2:0] == 3'd6);
    assign left_nxt      = (left_sr << 1) | DATA_W'(audio_sdout);
    assign right_nxt     = (right_sr << 1) | DATA_W'(audio_sdout);

    // Clock outputs are registered from the next count so they line up with cnt itself.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            audio_mclk <= 1'b0;
            audio_sck  <= 1'b0;
            audio_lrck <= 1'b0;
        end else begin
            cnt        <= cnt_nxt;
            audio_mclk <= cnt_nxt[1];
            audio_sck  <= cnt_nxt[2];
            audio_lrck <= cnt_nxt[8];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            left_sr   <= '0;
            left_hold <= '0;
            right_sr  <= '0;
        end else if (bit_strobe) begin
            if (!cnt[8]) begin
                left_sr <= left_nxt;
                if (last_bit) left_hold <= left_nxt;
            end else begin
                right_sr <= right_nxt;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= WARMUP;
            frame_cnt    <= '0;
            sample_left  <= '0;
            sample_right <= '0;
            sample_valid <= 1'b0;
            overrun      <= 1'b0;
`ifdef MONO_MIX_EN
            sample_mono  <= '0;
`endif
        end else begin
            overrun <= 1'b0;
            case (state)
                WARMUP: begin
                    if (frame_cnt == 4'(WARMUP_FRAMES)) state <= RUN;
                    else if (pair_complete) frame_cnt <= frame_cnt + 4'd1;
                end
                RUN: begin
                    if (pair_complete) begin
                        sample_left  <= left_hold;
                        sample_right <= right_sr;
                        sample_valid <= 1'b1;
                        overrun      <= sample_valid && !sample_ready;
`ifdef MONO_MIX_EN
                        sample_mono  <= DATA_W'(($signed({left_hold[DATA_W-1], left_hold})
                                               + $signed({right_sr[DATA_W-1], right_sr})) >>> 1);
`endif
                    end else if (sample_valid && sample_ready) begin
                        sample_valid <= 1'b0;
                    end
                end
                default: state <= WARMUP;
            endcase
        end
    end

endmodule
